// File: rtl/turbo_io_nibble_rx.sv
// Turbo I/O receive path: assembles strobed 4-bit nibbles (LSB nibble first)
// into full words and hands them to the core through a one-entry valid/ack register.
module turbo_io_nibble_rx #(
  parameter int NIBBLES = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           NIB_IN,
  input  logic                 NIB_STB,
  input  logic                 NIB_SOF,
  output logic                 NIB_RDY,
  output logic [4*NIBBLES-1:0] WORD_OUT,
  output logic                 WORD_VLD,
  input  logic                 WORD_ACK,
  output logic [3:0]           NIB_CNT,
  output logic                 OVF,
  output logic                 FRAME_ERR,
  input  logic                 ERR_CLR
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);

  logic [DATA_W-1:0] asm_p0;
  logic [DATA_W-1:0] word_p1;
  logic              vld_p1;
  logic [3:0]        cnt;
  logic              ovf;
  logic              frame_err;

  logic              rdy;
  logic              accept;
  logic              drop;
  logic              sof_mid;
  logic [3:0]        pos;
  logic              last;

  function automatic logic [3:0] next_pos(input logic [3:0] k);
    return (k == LAST) ? 4'd0 : k + 4'd1;
  endfunction

  // Ready is decoded from registered state only, so it never combinationally follows WORD_ACK.
  assign rdy     = !(vld_p1 && cnt == LAST);
  assign accept  = NIB_STB && rdy;
  assign drop    = NIB_STB && !rdy;
  assign pos     = NIB_SOF ? 4'd0 : cnt;
  assign last    = (pos == LAST);
  assign sof_mid = accept && NIB_SOF && (cnt != 4'd0);

  // Stage p0: nibble assembly and position counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      asm_p0 <= '0;
      cnt    <= 4'd0;
    end else if (accept) begin
      asm_p0[4*pos +: 4] <= NIB_IN;
      cnt                <= next_pos(pos);
    end
  end

  // Stage p1: holding register presented to the core
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (accept && last) begin
      word_p1 <= {NIB_IN, asm_p0[DATA_W-5:0]};
      vld_p1  <= 1'b1;
    end else if (WORD_ACK && vld_p1) begin
      vld_p1  <= 1'b0;
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (ERR_CLR) ovf <= 1'b0;
      if (sof_mid)      frame_err <= 1'b1;
      else if (ERR_CLR) frame_err <= 1'b0;
    end
  end

  assign NIB_RDY   = rdy;
  assign WORD_OUT  = word_p1;
  assign WORD_VLD  = vld_p1;
  assign NIB_CNT   = cnt;
  assign OVF       = ovf;
  assign FRAME_ERR = frame_err;

endmodule

// File: doc/turbo_io_nibble_rx.md
Name: turbo_io_nibble_rx

Overview:
- Receive side of the 4-bit turbo I/O link.
- Accepts a stream of 4-bit nibbles qualified by a strobe and assembles them LSB-nibble-first into full DLX words.
- Presents each completed word to the core through a single-entry valid/ack holding register.
- Sits between the 4-bit pad buffers and the core's word-wide input port, with back-pressure toward the nibble sender.

Parameters:
- NIBBLES, 8, nibbles per word; word width is 4*NIBBLES (32 by default); legal range 2..16.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- NIB_IN  input  4  nibble data, sampled when NIB_STB=1.
- NIB_STB  input  1  one-cycle nibble strobe.
- NIB_SOF  input  1  start-of-word marker, qualified by NIB_STB.
- NIB_RDY  output  1  receiver can accept a nibble this cycle.
- WORD_OUT  output  4*NIBBLES  assembled word; stable while WORD_VLD=1.
- WORD_VLD  output  1  holding register contains an unconsumed word.
- WORD_ACK  input  1  core consumes the word; ignored when WORD_VLD=0.
- NIB_CNT  output  4  index of the next nibble position (0..NIBBLES-1).
- OVF  output  1  sticky: a strobed nibble was dropped because NIB_RDY=0.
- FRAME_ERR  output  1  sticky: SOF arrived with a partial word pending.
- ERR_CLR  input  1  synchronous clear of OVF and FRAME_ERR.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - WORD_OUT=0, WORD_VLD=0, NIB_CNT=0, OVF=0, FRAME_ERR=0, assembly register=0.
  - NIB_RDY=1 once reset releases.
- NIB_RDY = !(WORD_VLD && NIB_CNT==NIBBLES-1). It is decoded from registered state only and never depends on WORD_ACK.
- Accept: a nibble is accepted when NIB_STB && NIB_RDY. It is written to assembly bits [4*k+3:4*k], where k=NIB_CNT or k=0 if NIB_SOF=1.
- Count: after an accept, NIB_CNT becomes k+1, or 0 when k==NIBBLES-1 (wrap).
- Word completion, when an accept hits k==NIBBLES-1:
  - Next cycle, WORD_OUT = {NIB_IN, assembly[4*(NIBBLES-1)-1:0]} and WORD_VLD=1.
  - Latency from last-nibble strobe to WORD_VLD is 1 cycle.
  - The assembly register is not cleared; stale upper nibbles are overwritten by the next word.
- SOF with NIB_CNT!=0 (accepted):
  - The partial word is discarded and the nibble is placed at position 0; NIB_CNT becomes 1.
  - FRAME_ERR is set.
  - SOF with NIB_CNT==0 is normal.
- Drop: NIB_STB && !NIB_RDY drops the nibble and sets OVF. NIB_CNT, the assembly register and WORD_OUT are unchanged.
- Ack: WORD_ACK && WORD_VLD clears WORD_VLD next cycle. NIB_RDY rises in the same cycle WORD_VLD falls.
- Completion and ack in the same cycle cannot occur: completion requires NIB_RDY, which implies WORD_VLD=0 at NIB_CNT==NIBBLES-1.
- Back-to-back operation:
  - With WORD_VLD=1 and NIB_CNT<NIBBLES-1, nibbles keep being accepted.
  - Throughput is one nibble per cycle while the core acks within NIBBLES-1 cycles.
- Sticky flags:
  - Set only by the events above; cleared by ERR_CLR.
  - A set event and ERR_CLR in the same cycle leave the flag set (set wins).
- WORD_OUT holds its value after ack until the next completion.
- Reset mid-word or with WORD_VLD=1 discards all state immediately; no word is presented afterwards.

Test Plan:
1. Reset release, then 8 strobes with NIB_SOF on the first and nibbles 1,2,...,8 -> WORD_OUT=0x87654321 and WORD_VLD=1 exactly 1 cycle after the 8th strobe; NIB_CNT=0.
2. Word A held un-acked while 7 nibbles of word B arrive -> NIB_RDY=0 at NIB_CNT=7. An 8th strobe is dropped, OVF=1, WORD_OUT still equals A. After WORD_ACK, resend the nibble -> WORD_OUT=B.
3. 3 nibbles, then an SOF strobe with 0xF followed by 7 more nibbles 0x0 -> FRAME_ERR=1, WORD_OUT=0x0000000F.
4. FRAME_ERR=1; ERR_CLR asserted in the same cycle as a new SOF-mid-word event -> FRAME_ERR stays 1. ERR_CLR alone next cycle -> FRAME_ERR=0.
5. Continuous 1-per-cycle strobes for 4 words, with WORD_ACK pulsed 2 cycles after each WORD_VLD rise -> no drops, OVF=0, all 4 words correct in order.
6. RST_N pulsed low asynchronously mid-word, at NIB_CNT=5 with WORD_VLD=1 -> all outputs are at reset values before the next CLK edge; a fresh 8-nibble word then assembles correctly.
